branch_predict_ctrl: RTL and testbench
======================================

# branch_predict_ctrl

Branch history controller for the superscalar core. It holds a table of 2-bit saturating counters. Fetch uses the table for a same-cycle taken/not-taken prediction, and the execute stage updates it with resolved branch outcomes. The block also turns the execute-stage mispredict indication into the fetch redirect/flush request, and keeps branch and mispredict statistics. After reset it sequences its own table initialisation before it accepts lookups or updates.

## Interface
Parameters:
- ENTRIES, 64, number of counter entries; must be a power of two, ≥ 4.
- INDEX_W, $clog2(ENTRIES), table index width (derived; do not override).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- fetch_pc_i  in  32  PC of the instruction being fetched.
- predict_taken_o  out  1  prediction for fetch_pc_i (combinational).
- ready_o  out  1  table initialised; lookups and updates are live.
- update_valid_i  in  1  a conditional branch resolved in execute this cycle.
- update_pc_i  in  32  PC of the resolved branch.
- update_taken_i  in  1  actual outcome of the resolved branch.
- mispredict_i  in  1  execute detected a misprediction this cycle.
- mispredict_target_i  in  32  corrected PC from execute.
- redirect_valid_o  out  1  fetch must load redirect_pc_o.
- redirect_pc_o  out  32  redirect target.
- flush_o  out  1  squash the IF/ID and ID/EX pipeline registers.
- branch_count_o  out  32  number of resolved branches accepted.
- mispredict_count_o  out  32  number of mispredicts accepted.

## Operation
- Index = pc[INDEX_W+1:2]. Bits [1:0] are ignored and higher bits alias.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - Prediction = counter[1].
  - Counters initialise to 01.
- Two-state FSM, INIT and RUN:
  - INIT: init_ptr walks from 0 to ENTRIES-1. Each cycle writes 01 to table[init_ptr], then increments init_ptr. The cycle that writes ENTRIES-1 transitions to RUN.
  - RUN: terminal state; only reset leaves it.
- In INIT:
  - ready_o=0 and predict_taken_o=0.
  - update_valid_i and mispredict_i are ignored: no table write, no count change, redirect_valid_o=0, flush_o=0.
- In RUN, update_valid_i=1 updates the indexed counter:
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
  - branch_count_o increments, saturating at 32'hFFFF_FFFF.
- In RUN, mispredict_i=1:
  - redirect_valid_o=1, redirect_pc_o=mispredict_target_i, flush_o=1, all in the same cycle (combinational).
  - mispredict_count_o increments, saturating.
  - mispredict_i without update_valid_i is still honoured and counted.
- When redirect_valid_o=0, redirect_pc_o=0.
- Read/write collision: in RUN, if update_valid_i=1 and the update index equals the fetch index, predict_taken_o returns bit [1] of the post-update counter (bypass).

## Timing
- Reset values:
  - state=INIT, init_ptr=0, ready_o=0, predict_taken_o=0.
  - redirect_valid_o=0, redirect_pc_o=0, flush_o=0.
  - Both counts are 0.
  - Table contents are undefined until INIT completes.
- ready_o rises exactly ENTRIES rising edges after rst_n deasserts.
- Lookups have zero latency: predict_taken_o is combinational from fetch_pc_i and the table.
- Updates become visible to non-bypassed lookups from the cycle after the update edge.
- Redirect and flush have zero latency from mispredict_i; fetch and the pipeline registers act on them at the next edge.
- Counts reflect an event from the cycle after the event.
- Reset asserted mid-INIT or mid-RUN: everything returns to the reset values immediately (asynchronous), and INIT restarts from index 0.
- Two updates to the same index on consecutive cycles: the second update operates on the first update's result.

## Structure
- bp_pkg holds:
  - typedef bht_ctr_t (logic [1:0]).
  - Constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - enum bp_state_e {BP_INIT, BP_RUN}.
  - Function sat2_next(ctr, taken), shared with future BHT variants.
- No sub-module: the table is a flop array inside branch_predict_ctrl, because the single write port is shared between the INIT sweep and updates.

## Test plan
- Reset, ENTRIES=64, fetch_pc_i=0x100 held → ready_o=0 and predict_taken_o=0 for 64 cycles; ready_o=1 from cycle 64, predict_taken_o=0 (counter 01).
- After ready, two updates of PC 0x40 taken → lookup of 0x40 gives 1. A third and fourth taken update, then one not-taken → counter 10, still predicts 1. Lookup of 0x140 (aliases at 64 entries) also gives 1.
- Same-cycle update of 0x80 taken (counter 01→10) while fetch_pc_i=0x80 → predict_taken_o=1 in that cycle (bypass).
- mispredict_i=1, mispredict_target_i=0x2004 → redirect_valid_o=1, redirect_pc_o=0x2004, flush_o=1 in the same cycle; mispredict_count_o goes 0→1 the next cycle.
- update_valid_i=1 and mispredict_i=1 during INIT → no redirect, no flush, counts stay 0. Entry at that index reads 01 after ready.
- Reset pulsed while in RUN with counts at 5/2 → counts become 0 and ready_o becomes 0 immediately; INIT repeats its full 64 cycles.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch history table controllers.
package bp_pkg;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t CTR_SNT = 2'b00;
  localparam bht_ctr_t CTR_WNT = 2'b01;
  localparam bht_ctr_t CTR_WT  = 2'b10;
  localparam bht_ctr_t CTR_ST  = 2'b11;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  // 2-bit saturating counter step toward the resolved outcome.
  function automatic bht_ctr_t sat2_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    if (taken) begin
      nxt = (ctr == CTR_ST) ? CTR_ST : bht_ctr_t'(ctr + 2'd1);
    end else begin
      nxt = (ctr == CTR_SNT) ? CTR_SNT : bht_ctr_t'(ctr - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl.sv
// Bimodal branch history table with self-initialisation, mispredict redirect
// and branch/mispredict statistics.
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int INDEX_W = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc_i,
  output logic        predict_taken_o,
  output logic        ready_o,
  input  logic        update_valid_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i,
  input  logic        mispredict_i,
  input  logic [31:0] mispredict_target_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic [31:0] branch_count_o,
  output logic [31:0] mispredict_count_o
);

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(ENTRIES - 1);
  localparam logic [31:0]        CNT_MAX  = 32'hFFFF_FFFF;

  bp_state_e          state_r;
  logic [INDEX_W-1:0] init_ptr_r;
  bht_ctr_t           table_r [ENTRIES];
  logic [31:0]        branch_count_r;
  logic [31:0]        mispredict_count_r;

  logic               run_s;
  logic [INDEX_W-1:0] fetch_idx_s;
  logic [INDEX_W-1:0] upd_idx_s;
  bht_ctr_t           upd_next_s;
  logic               unused_s;

  assign run_s       = (state_r == BP_RUN);
  assign fetch_idx_s = fetch_pc_i[INDEX_W+1:2];
  assign upd_idx_s   = update_pc_i[INDEX_W+1:2];
  assign upd_next_s  = sat2_next(table_r[upd_idx_s], update_taken_i);
  assign unused_s    = ^{fetch_pc_i[31:INDEX_W+2], fetch_pc_i[1:0],
                         update_pc_i[31:INDEX_W+2], update_pc_i[1:0]};

  assign ready_o            = run_s;
  assign branch_count_o     = branch_count_r;
  assign mispredict_count_o = mispredict_count_r;

  // Init sweep and RUN-phase statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= BP_INIT;
      init_ptr_r         <= '0;
      branch_count_r     <= 32'd0;
      mispredict_count_r <= 32'd0;
    end else begin
      case (state_r)
        BP_INIT: begin
          init_ptr_r <= init_ptr_r + INDEX_W'(1);
          if (init_ptr_r == LAST_IDX) begin
            state_r <= BP_RUN;
          end
        end
        BP_RUN: begin
          if (update_valid_i && (branch_count_r != CNT_MAX)) begin
            branch_count_r <= branch_count_r + 32'd1;
          end
          if (mispredict_i && (mispredict_count_r != CNT_MAX)) begin
            mispredict_count_r <= mispredict_count_r + 32'd1;
          end
        end
        default: begin
          state_r <= BP_INIT;
        end
      endcase
    end
  end

  // Single table write port, shared by the init sweep and resolved updates;
  // contents are deliberately left unreset since INIT overwrites every entry.
  always_ff @(posedge clk) begin
    if (!run_s) begin
      table_r[init_ptr_r] <= CTR_WNT;
    end else if (update_valid_i) begin
      table_r[upd_idx_s] <= upd_next_s;
    end
  end

  // Same-cycle lookup with bypass of a colliding update.
  always_comb begin
    predict_taken_o = 1'b0;
    if (!run_s) begin
      predict_taken_o = 1'b0;
    end else if (update_valid_i && (upd_idx_s == fetch_idx_s)) begin
      predict_taken_o = upd_next_s[1];
    end else begin
      predict_taken_o = table_r[fetch_idx_s][1];
    end
  end

  // Mispredict turns directly into a fetch redirect and pipeline flush.
  always_comb begin
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'd0;
    flush_o          = 1'b0;
    if (run_s && mispredict_i) begin
      redirect_valid_o = 1'b1;
      redirect_pc_o    = mispredict_target_i;
      flush_o          = 1'b1;
    end else begin
      redirect_valid_o = 1'b0;
      redirect_pc_o    = 32'd0;
      flush_o          = 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: a reference model pushes the
// expected outputs for each driven cycle, which are popped and compared.
module tb_branch_predict_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        predict_taken;
  logic        ready;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        mispredict;
  logic [31:0] mispredict_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_predict_ctrl #(.ENTRIES(64)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fetch_pc_i          (fetch_pc),
    .predict_taken_o     (predict_taken),
    .ready_o             (ready),
    .update_valid_i      (update_valid),
    .update_pc_i         (update_pc),
    .update_taken_i      (update_taken),
    .mispredict_i        (mispredict),
    .mispredict_target_i (mispredict_target),
    .redirect_valid_o    (redirect_valid),
    .redirect_pc_o       (redirect_pc),
    .flush_o             (flush),
    .branch_count_o      (branch_count),
    .mispredict_count_o  (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        pred;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        fl;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  // Reference model state
  int          m_tab [64];
  bit          m_run;
  int          m_ptr;
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic int step(input int c, input logic t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_ptr = 0;
    m_bc  = 32'd0;
    m_mc  = 32'd0;
  endtask

  // One clock cycle: drive, push expectation, sample mid-cycle, then advance.
  task automatic cyc(input string tag, input logic [31:0] fpc, input logic uv,
                     input logic [31:0] upc, input logic ut, input logic mp,
                     input logic [31:0] mt);
    exp_t e;
    exp_t g;
    int   c;
    fetch_pc          = fpc;
    update_valid      = uv;
    update_pc         = upc;
    update_taken      = ut;
    mispredict        = mp;
    mispredict_target = mt;
    e.tag  = tag;
    e.rdy  = m_run;
    e.bc   = m_bc;
    e.mc   = m_mc;
    e.rv   = m_run && mp;
    e.fl   = m_run && mp;
    e.rpc  = (m_run && mp) ? mt : 32'd0;
    if (!m_run) begin
      e.pred = 1'b0;
    end else if (uv && idx_of(upc) == idx_of(fpc)) begin
      c = step(m_tab[idx_of(upc)], ut);
      e.pred = (c >= 2);
    end else begin
      e.pred = (m_tab[idx_of(fpc)] >= 2);
    end
    exp_q.push_back(e);
    #3;
    g = exp_q.pop_front();
    check_val({g.tag, ".pred"},  {31'd0, predict_taken},  {31'd0, g.pred});
    check_val({g.tag, ".ready"}, {31'd0, ready},          {31'd0, g.rdy});
    check_val({g.tag, ".rv"},    {31'd0, redirect_valid}, {31'd0, g.rv});
    check_val({g.tag, ".rpc"},   redirect_pc,             g.rpc);
    check_val({g.tag, ".flush"}, {31'd0, flush},          {31'd0, g.fl});
    check_val({g.tag, ".bcnt"},  branch_count,            g.bc);
    check_val({g.tag, ".mcnt"},  mispredict_count,        g.mc);
    @(posedge clk);
    if (!m_run) begin
      m_tab[m_ptr] = 1;
      if (m_ptr == 63) m_run = 1'b1;
      m_ptr = (m_ptr + 1) % 64;
    end else begin
      if (uv) begin
        m_tab[idx_of(upc)] = step(m_tab[idx_of(upc)], ut);
        if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
      end
      if (mp && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 32'd1;
    end
    #1;
  endtask

  task automatic idle(input string tag, input logic [31:0] fpc);
    cyc(tag, fpc, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_val({tag, ".rst_ready"}, {31'd0, ready},  32'd0);
    check_val({tag, ".rst_pred"},  {31'd0, predict_taken}, 32'd0);
    check_val({tag, ".rst_bcnt"},  branch_count,     32'd0);
    check_val({tag, ".rst_mcnt"},  mispredict_count, 32'd0);
    check_val({tag, ".rst_rv"},    {31'd0, redirect_valid}, 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] pcs [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    fetch_pc = 32'h100;
    update_valid = 1'b0;
    update_pc = 32'd0;
    update_taken = 1'b0;
    mispredict = 1'b1;
    mispredict_target = 32'h1234;
    model_reset();
    @(posedge clk);
    #1;
    check_val("reset.ready", {31'd0, ready}, 32'd0);
    check_val("reset.pred",  {31'd0, predict_taken}, 32'd0);
    check_val("reset.rv",    {31'd0, redirect_valid}, 32'd0);
    check_val("reset.rpc",   redirect_pc, 32'd0);
    check_val("reset.flush", {31'd0, flush}, 32'd0);
    check_val("reset.bcnt",  branch_count, 32'd0);
    check_val("reset.mcnt",  mispredict_count, 32'd0);
    rst_n = 1'b1;

    // INIT sweep, with updates and mispredicts that must be ignored
    for (int i = 0; i < 64; i++) begin
      if (i == 10 || i == 40)
        cyc("init_ign", 32'h100, 1'b1, 32'h0C0, 1'b1, 1'b1, 32'h1234);
      else
        idle("init", 32'h100);
    end
    idle("ready", 32'h100);
    idle("ign_entry", 32'h0C0);

    // Training PC 0x40
    cyc("upd40a", 32'h100, 1'b1, 32'h40, 1'b1, 1'b0, 32'd0);
    cyc("upd40b", 32'h100, 1'b1, 32'h40, 1'b1, 1'b0, 32'd0);
    idle("look40", 32'h40);
    cyc("upd40c", 32'h100, 1'b1, 32'h40, 1'b1, 1'b0, 32'd0);
    cyc("upd40d", 32'h100, 1'b1, 32'h40, 1'b1, 1'b0, 32'd0);
    cyc("upd40nt", 32'h100, 1'b1, 32'h40, 1'b0, 1'b0, 32'd0);
    idle("look40w", 32'h40);
    idle("alias140", 32'h140);

    // Same-cycle bypass
    cyc("bypass80", 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 32'd0);
    idle("after80", 32'h80);

    // Mispredict alone, then with an update
    cyc("misp", 32'h100, 1'b0, 32'd0, 1'b0, 1'b1, 32'h2004);
    idle("misp_cnt", 32'h100);
    cyc("misp_upd", 32'h84, 1'b1, 32'h84, 1'b0, 1'b1, 32'hDEAD_BEE0);

    // Randomised traffic over a few aliasing indices
    pcs[0] = 32'h40;  pcs[1] = 32'h44;  pcs[2] = 32'h140;  pcs[3] = 32'h80;
    for (int i = 0; i < 200; i++) begin
      cyc("rand", pcs[$urandom_range(3, 0)], 1'($urandom_range(1, 0)),
          pcs[$urandom_range(3, 0)], 1'($urandom_range(1, 0)),
          ($urandom_range(3, 0) == 0), $urandom);
    end

    // Reset mid-RUN, then mid-INIT, then a full INIT again
    pulse_reset("rst_run");
    for (int i = 0; i < 20; i++) idle("reinit", 32'h40);
    pulse_reset("rst_init");
    for (int i = 0; i < 64; i++) idle("reinit2", 32'h40);
    idle("ready2", 32'h40);
    cyc("misp2", 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h3000);
    idle("post2", 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
